// File: rtl/ifid_bt_pkg.sv
// Shared types and constants for the IF/ID branch-target block.
package ifid_bt_pkg;

  typedef enum logic [1:0] {
    BT_BR   = 2'd0,
    BT_JAL  = 2'd1,
    BT_JALR = 2'd2,
    BT_NONE = 2'd3
  } bt_mode_e;

  localparam int BT_LINK_INC = 4;
  localparam int BT_ADDR_W   = 32;
  localparam int BT_DATA_W   = 32;

endpackage

// File: rtl/ifid_branch_target_if.sv
// Decode-side request and fetch-redirect result bundle for ifid_branch_target.
// slave is the block's view; master is the upstream/downstream driver's view.
interface ifid_branch_target_if
  import ifid_bt_pkg::*;
#(
  parameter int ADDR_W = BT_ADDR_W,
  parameter int DATA_W = BT_DATA_W
) ();

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  bt_mode_e          in_mode;
  logic [ADDR_W-1:0] in_pc;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] in_rs1;
  logic              in_rd_link;
  logic              in_rs1_link;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_target;
  logic [ADDR_W-1:0] out_link;
  logic              out_misalign;
  logic              out_ras_hit;

  modport slave (
    input  flush, in_valid, in_mode, in_pc, in_imm, in_rs1, in_rd_link, in_rs1_link,
    input  out_ready,
    output in_ready, out_valid, out_target, out_link, out_misalign, out_ras_hit
  );

  modport master (
    output flush, in_valid, in_mode, in_pc, in_imm, in_rs1, in_rd_link, in_rs1_link,
    output out_ready,
    input  in_ready, out_valid, out_target, out_link, out_misalign, out_ras_hit
  );

endinterface

// File: rtl/ifid_ras.sv
// Circular return-address stack; push/pop take effect on the clock edge, top is combinational.
// Overflow overwrites the oldest entry, pop on empty is ignored, pop+push replaces the top.
module ifid_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] top_dat,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;

  // ptr_q is the next free slot; the top lives one below it (mod DEPTH)
  assign top_idx = ptr_q - PTR_W'(1);
  assign top_dat = mem_q[top_idx];
  assign empty   = (cnt_q == '0);

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_vld && pop_vld && !empty) begin
      mem_d[top_idx] = push_dat;
    end else if (push_vld) begin
      mem_d[ptr_q] = push_dat;
      ptr_d        = ptr_q + PTR_W'(1);
      if (cnt_q != (PTR_W+1)'(DEPTH)) cnt_d = cnt_q + (PTR_W+1)'(1);
    end else if (pop_vld && !empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/ifid_branch_target.sv
// Registered BR/JAL/JALR target + link generator, 1-cycle latency, one-deep valid/ready output with flush.
// Optional return-address stack prediction under `define IFID_BT_RAS_EN.
module ifid_branch_target
  import ifid_bt_pkg::*;
#(
  parameter int ADDR_W    = BT_ADDR_W,
  parameter int DATA_W    = BT_DATA_W,
  parameter int IALIGN    = 4,
  parameter int RAS_DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  ifid_branch_target_if.slave bt
);

  logic              accept;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] rs1_ext;
  logic [ADDR_W-1:0] jalr_sum;
  logic [ADDR_W-1:0] calc_target;
  logic [ADDR_W-1:0] link;
  logic [ADDR_W-1:0] sel_target;
  logic              sel_ras_hit;

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] link_q, link_d;
  logic              misalign_q, misalign_d;
  logic              ras_hit_q, ras_hit_d;

  // Operands narrower than the address are sign-extended (imm) / zero-extended (rs1)
  if (DATA_W >= ADDR_W) begin : g_trunc
    assign imm_ext = bt.in_imm[ADDR_W-1:0];
    assign rs1_ext = bt.in_rs1[ADDR_W-1:0];
  end else begin : g_ext
    assign imm_ext = {{(ADDR_W-DATA_W){bt.in_imm[DATA_W-1]}}, bt.in_imm};
    assign rs1_ext = {{(ADDR_W-DATA_W){1'b0}}, bt.in_rs1};
  end

  assign bt.in_ready = !valid_q || bt.out_ready;
  assign accept      = bt.in_valid && bt.in_ready && !bt.flush;
  assign link        = bt.in_pc + ADDR_W'(BT_LINK_INC);
  assign jalr_sum    = rs1_ext + imm_ext;

  always_comb begin
    calc_target = link;
    unique case (bt.in_mode)
      BT_BR, BT_JAL: calc_target = bt.in_pc + (imm_ext << 1);
      BT_JALR:       calc_target = {jalr_sum[ADDR_W-1:1], 1'b0};
      default:       calc_target = link;
    endcase
  end

`ifdef IFID_BT_RAS_EN
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;

  // Register numbers are not visible here, so both link flags set is treated as rs1 != rd (pop then push)
  assign ras_push = accept && bt.in_rd_link &&
                    ((bt.in_mode == BT_JAL) || (bt.in_mode == BT_JALR));
  assign ras_pop  = accept && bt.in_rs1_link && (bt.in_mode == BT_JALR);

  ifid_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (ras_push),
    .push_dat (link),
    .pop_vld  (ras_pop),
    .top_dat  (ras_top),
    .empty    (ras_empty)
  );

  assign sel_ras_hit = (bt.in_mode == BT_JALR) && bt.in_rs1_link && !ras_empty;
  assign sel_target  = sel_ras_hit ? ras_top : calc_target;
`else
  logic unused_ras;
  assign unused_ras  = ^{bt.in_rd_link, bt.in_rs1_link, RAS_DEPTH[4:0]};
  assign sel_ras_hit = 1'b0;
  assign sel_target  = calc_target;
`endif

  always_comb begin
    valid_d    = valid_q;
    target_d   = target_q;
    link_d     = link_q;
    misalign_d = misalign_q;
    ras_hit_d  = ras_hit_q;
    if (bt.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      target_d   = sel_target;
      link_d     = link;
      misalign_d = (IALIGN == 4) ? sel_target[1] : 1'b0;
      ras_hit_d  = sel_ras_hit;
    end else if (bt.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      target_q   <= '0;
      link_q     <= '0;
      misalign_q <= 1'b0;
      ras_hit_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      target_q   <= target_d;
      link_q     <= link_d;
      misalign_q <= misalign_d;
      ras_hit_q  <= ras_hit_d;
    end
  end

  assign bt.out_valid    = valid_q;
  assign bt.out_target   = target_q;
  assign bt.out_link     = link_q;
  assign bt.out_misalign = misalign_q;
  assign bt.out_ras_hit  = ras_hit_q;

endmodule

// File: doc/ifid_branch_target.md
Name: ifid_branch_target

Overview:
Parametrised, registered successor to the IF/ID branch-offset adder.
- Computes the control-transfer target and link address for BRANCH, JAL and JALR.
- Checks target alignment.
- Presents results through a one-deep valid/ready output register with flush.
- Sits between decode and the fetch redirect logic.

Parameters:
ADDR_W, 32, instruction-memory address width (pc, target, link).
DATA_W, 32, signed immediate / rs1 operand width.
IALIGN, 4, required target alignment in bytes; legal values 2 or 4.
RAS_DEPTH, 4, return-address-stack entries; power of two, 2..16. Used only with the optional feature.

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  discard held and incoming requests
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
in_mode  input  2  bt_mode_e: BR=0, JAL=1, JALR=2, NONE=3
in_pc  input  ADDR_W  pc of the instruction
in_imm  input  DATA_W  signed immediate, halfword units for BR/JAL, bytes for JALR
in_rs1  input  DATA_W  rs1 value for JALR
in_rd_link  input  1  rd is x1 or x5
in_rs1_link  input  1  rs1 is x1 or x5
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_target  output  ADDR_W  computed target
out_link  output  ADDR_W  in_pc + 4
out_misalign  output  1  target not IALIGN-aligned
out_ras_hit  output  1  target came from RAS (0 without the optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_target=0, out_link=0, out_misalign=0, out_ras_hit=0. RAS pointer and count go to 0.
- in_ready = !out_valid || out_ready. This is combinational and does not depend on flush.
- Accept when in_valid && in_ready && !flush. The result is registered with 1-cycle latency; out_valid is 1 the cycle after acceptance.
- Target arithmetic:
  - imm is sign-extended/truncated to ADDR_W.
  - BR/JAL: pc + (imm << 1).
  - JALR: (rs1[ADDR_W-1:0] + imm) with bit 0 cleared.
  - NONE: pc + 4.
  - All sums are modulo 2^ADDR_W; wrap-around is silent and is not an error.
- out_link = pc + 4, also modulo 2^ADDR_W.
- out_misalign = target[1] when IALIGN=4; constant 0 when IALIGN=2. The flag is reported, never suppressed; the target is still output.
- Hold: while out_valid && !out_ready, all out_* stay stable.
- Completion: out_valid && out_ready with no new accept drops out_valid to 0 next cycle. A same-cycle accept loads the new result (back-to-back throughput of 1/cycle).
- Flush: out_valid=0 next cycle, and any same-cycle input is dropped. Flush has priority over accept and over hold. Output data registers keep their last values.
- Reset asserted mid-transaction clears everything immediately. There is no pending state after release.

Optional Feature:
Macro IFID_BT_RAS_EN.
- Defined: RAS_DEPTH-entry circular return-address stack, updated on accept.
  - JAL/JALR with in_rd_link=1: push out_link.
  - JALR with in_rs1_link=1 and in_rd_link=0: pop. If the stack is non-empty, out_target = popped entry and out_ras_hit=1; otherwise use the computed target with out_ras_hit=0.
  - JALR with both link flags set and rs1 register != rd: pop then push, in the same cycle.
  - Overflow overwrites the oldest entry; count saturates at RAS_DEPTH. Pop on empty leaves state unchanged.
  - Flush does not alter the RAS.
- Undefined: no RAS storage, out_ras_hit tied 0, link inputs ignored.

Decomposition:
- Package ifid_bt_pkg: bt_mode_e enum, BT_LINK_INC=4, default ADDR_W/DATA_W constants.
- One sub-module, ifid_ras (push/pop/count/circular pointer), instantiated only under IFID_BT_RAS_EN.

Test Plan:
- BR, pc=0x100, imm=-8 -> target 0xF0, link 0x104, misalign 0, out_valid one cycle after accept.
- JALR, rs1=0x2003, imm=4, IALIGN=4 -> target 0x2006, misalign=1. Repeat with IALIGN=2 -> misalign=0.
- JAL, pc=0xFFFFFFFC, imm=4 -> target 0x00000004 (wrap), link 0x00000000.
- out_ready held 0 for 3 cycles with a new in_valid pending -> in_ready=0, outputs stable. Release -> back-to-back results with no bubble.
- flush in the same cycle as in_valid, with a held result -> next cycle out_valid=0 and the request is not produced. rst_n pulse mid-hold -> all outputs 0 immediately.
- IFID_BT_RAS_EN, RAS_DEPTH=4:
  - 5 JAL rd=x1 at pc 0x10,0x20,...,0x50, then 5 JALR ret -> hits 0x54,0x44,0x34,0x24, then miss with computed target.
